uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serial transmit side of the board UART link: accepts bytes from the processor/host side and drives the `tx` line as 8N1 frames, LSB first.
- Shares the 16x-oversampled baud enable `clken` with the existing receiver; each bit is held for TICKS_PER_BIT enable pulses.
- A small input FIFO lets the core queue several bytes (e.g. processed image samples) without waiting on the line.

Parameters:
- TICKS_PER_BIT, 16, clken pulses per serial bit (start, data and stop); must be ≥2.
- FIFO_DEPTH, 4, input queue entries; power of two, ≥2.
- FIFO_AW, 2, log2(FIFO_DEPTH); pointer width.

Ports:
- clk_  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clken  input  1  baud oversample enable, one clk_ cycle wide.
- din  input  8  byte to queue.
- wr_en  input  1  push din when high (one byte per cycle).
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- overflow  output  1  sticky: write attempted while full; cleared only by rst.
- busy  output  1  high whenever state != IDLE.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-frame): tx=1, busy=0, full=0, empty=1, overflow=0, state=IDLE, FIFO pointers/count=0, tick and bit counters=0. An in-flight frame is aborted; the line returns high immediately.
- FIFO:
  - full and empty are registered from the count.
  - A write with full=1 is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Simultaneous push (not full) and pop: count unchanged, both take effect.
- States:
  - IDLE:
    - tx=1.
    - On any clk_ edge with empty=0, pop the head byte into an 8-bit shift register, set tx=0, go to START, tick=0.
    - This transition is not gated by clken.
  - START:
    - On each clken, tick++.
    - When tick reaches TICKS_PER_BIT-1 with clken: tick=0, bit=0, tx=shift[0], go to DATA.
  - DATA:
    - On each clken, tick++.
    - At tick=TICKS_PER_BIT-1 with clken: tick=0, shift right.
    - If bit=7: tx=1 and go to STOP.
    - Otherwise: bit++ and tx=next LSB.
  - STOP:
    - tx=1.
    - At tick=TICKS_PER_BIT-1 with clken: tick=0.
    - If empty=0, pop the next byte, tx=0 and go to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Frame length: exactly 10*TICKS_PER_BIT clken pulses from the first low tx cycle to the end of the stop bit.
- clken low: all counters hold; tx holds.
- tx, busy, full, empty and overflow are registered outputs (no combinational path from inputs).
- A write to an empty FIFO while in IDLE: the byte appears at the FIFO head the next cycle; tx falls one cycle after that (2-cycle wr_en→tx latency).

Decomposition:
- Shared package/header `uart_defs`:
  - state encodings TX_IDLE/TX_START/TX_DATA/TX_STOP (2 bits);
  - default TICKS_PER_BIT=16 (shared with the receiver);
  - UART_DATA_BITS=8.
- One sub-module, `uart_tx_fifo`:
  - synchronous FIFO parameterised by FIFO_DEPTH/FIFO_AW;
  - ports clk_, rst, wr_en, din, rd_en, dout, full, empty, overflow.
- The FSM and shift register live in `uart_transmitter`.

Test Plan:
1. Reset, clken=1 every cycle; write 0x55 -> tx low for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles; busy high 160 cycles, then 0; a loop-back uart_receiver must report data=0x55 with rdy=1.
2. clken every 4th cycle; write 0xA3 -> start bit lasts 64 clk_ cycles; data LSB-first 1,1,0,0,0,1,0,1; total frame 640 clk_ cycles.
3. Write 0x01, 0x02, 0x03 on consecutive cycles -> three frames with no idle gap (STOP→START direct); tx never high longer than 16 ticks between frames; receiver yields 0x01, 0x02, 0x03 in order.
4. Hold tx busy; write 5 bytes with FIFO_DEPTH=4 while the first frame is already popped -> 4 queued, full=1; the 6th write is dropped and overflow=1 sticky; exactly 5 frames are sent.
5. Assert rst midway through the DATA bits of 0xF0 -> the next cycle shows tx=1, busy=0, empty=1, overflow=0; a new write of 0x3C is then sent as a clean full frame.
6. Push and the STOP-state pop in the same cycle with the FIFO full -> the push is dropped and overflow=1; count ends at FIFO_DEPTH-1.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions: transmitter state encoding and frame constants.
// The receiver imports the same tick default so both ends agree on the bit period.
package uart_defs;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  localparam int UART_TICKS_PER_BIT = 16;
  localparam int UART_DATA_BITS     = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO queueing bytes for the transmitter.
// Head entry is visible on dout; flags are registered from the next-state count.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2,
  parameter int DATA_W     = 8
) (
  input  logic              clk_,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [FIFO_AW:0]   count_d;
  logic               full_q;
  logic               empty_q;
  logic               overflow_q;
  logic               do_push;
  logic               do_pop;

  // A write while full is lost even if a pop frees a slot in the same cycle.
  assign do_push = wr_en && !full_q;
  assign do_pop  = rd_en && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      full_q     <= (count_d == FULL_COUNT);
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_q | (wr_en & full_q);
    end
  end

  always_ff @(posedge clk_) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout     = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed from a small FIFO, paced by the shared 16x baud enable.
// Frames run back to back whenever the FIFO still holds data at the end of a stop bit.
module uart_transmitter
  import uart_defs::*;
#(
  parameter int TICKS_PER_BIT = uart_defs::UART_TICKS_PER_BIT,
  parameter int FIFO_DEPTH    = 4,
  parameter int FIFO_AW       = 2
) (
  input  logic       clk_,
  input  logic       rst,
  input  logic       clken,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);

  localparam int              TICK_W    = $clog2(TICKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);

  tx_state_e          state_q;
  tx_state_e          state_d;
  logic [TICK_W-1:0]  tick_q;
  logic [TICK_W-1:0]  tick_d;
  logic [2:0]         bit_q;
  logic [2:0]         bit_d;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic               tx_q;
  logic               tx_d;
  logic               busy_q;
  logic               fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic               fifo_empty;
  logic               tick_done;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW),
    .DATA_W     (UART_DATA_BITS)
  ) u_fifo (
    .clk_     (clk_),
    .rst      (rst),
    .wr_en    (wr_en),
    .din      (din),
    .rd_en    (fifo_pop),
    .dout     (fifo_dout),
    .full     (full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign tick_done = clken && (tick_q == TICK_LAST);

  always_ff @(posedge clk_) begin
    if (rst) begin
      state_q <= TX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != TX_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (!fifo_empty) state_d = TX_START;
      TX_START: if (tick_done) state_d = TX_DATA;
      TX_DATA:  if (tick_done && bit_q == 3'd7) state_d = TX_STOP;
      TX_STOP:  if (tick_done) state_d = fifo_empty ? TX_IDLE : TX_START;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        // Leaving idle is not paced by clken, so latency from write to start bit stays fixed.
        tx_d   = 1'b1;
        tick_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (tick_done) begin
          tick_d = '0;
          bit_d  = '0;
          tx_d   = shift_q[0];
        end else if (clken) begin
          tick_d = tick_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tick_done) begin
          tick_d  = '0;
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end else if (clken) begin
          tick_d = tick_q + 1'b1;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (tick_done) begin
          tick_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
          end
        end else if (clken) begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign empty = fifo_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomised bench for uart_transmitter: a queue-and-frame-counter line model predicts
// every cycle of tx/busy/flags, and a sampling receiver recovers each byte from the line.
module tb_uart_transmitter;

  localparam int T = 16;
  localparam int D = 4;

  logic       clk_ = 1'b0;
  logic       rst;
  logic       clken;
  logic [7:0] din;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       busy;
  logic       tx;

  uart_transmitter #(
    .TICKS_PER_BIT (T),
    .FIFO_DEPTH    (D),
    .FIFO_AW       (2)
  ) dut (
    .clk_     (clk_),
    .rst      (rst),
    .clken    (clken),
    .din      (din),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk_ = ~clk_;

  int n_checks = 0;
  int n_errors = 0;

  // Line model: bytes waiting in the queue, current frame and clken pulses since its start bit began.
  byte unsigned q[$];
  bit          in_frame = 1'b0;
  int          cnt = 0;
  logic [9:0]  frame = '1;
  logic [7:0]  cur = '0;
  logic [7:0]  dec = '0;
  bit          m_ovf = 1'b0;
  int          div = 1;
  int          div_cnt = 0;
  bit          rand_clken = 1'b0;
  int          n_frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit   accept;
    logic exp_tx;
    if (rand_clken) begin
      clken = ($urandom_range(0, 2) == 0);
    end else begin
      clken   = (div_cnt == 0);
      div_cnt = (div_cnt + 1) % div;
    end
    accept = wr_en && (q.size() < D);
    if (rst) begin
      q.delete();
      in_frame = 1'b0;
      cnt      = 0;
      m_ovf    = 1'b0;
    end else begin
      if (wr_en && q.size() == D) m_ovf = 1'b1;
      if (in_frame && clken) begin
        cnt++;
        if (cnt == 10 * T) begin
          n_frames++;
          $display("frame %0d: sent %02h received %02h", n_frames, cur, dec);
          check("rx_byte", {24'd0, dec}, {24'd0, cur});
          in_frame = 1'b0;
        end
      end
      if (!in_frame && q.size() > 0) begin
        cur      = q.pop_front();
        frame    = {1'b1, cur, 1'b0};
        in_frame = 1'b1;
        cnt      = 0;
        dec      = '0;
      end
      if (accept) q.push_back(din);
    end
    @(posedge clk_);
    #1;
    exp_tx = in_frame ? frame[cnt / T] : 1'b1;
    check("tx", {31'd0, tx}, {31'd0, exp_tx});
    check("busy", {31'd0, busy}, {31'd0, in_frame});
    check("full", {31'd0, full}, {31'd0, (q.size() == D)});
    check("empty", {31'd0, empty}, {31'd0, (q.size() == 0)});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (in_frame && clken && (cnt % T == T / 2) && cnt >= T && cnt < 9 * T)
      dec[cnt / T - 1] = tx;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    din   = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_div(input int d);
    rand_clken = 1'b0;
    div        = d;
    div_cnt    = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((in_frame || q.size() > 0) && n < 20000) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, {31'd0, (n < 20000)}, 32'd1);
    repeat (3) step();
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    din   = '0;
    clken = 1'b0;
    set_div(1);
    do_reset();

    // Single frame at full enable rate.
    write_byte(8'h55);
    drain("t1");

    // Sparse enable stretches every bit fourfold.
    set_div(4);
    write_byte(8'hA3);
    drain("t2");

    // Back-to-back frames.
    set_div(1);
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    drain("t3");

    // Fill the FIFO behind a frame in flight and overrun it once.
    write_byte(8'h11);
    step();
    for (int i = 0; i < 5; i++) write_byte(8'h20 + 8'(i));
    drain("t4");

    // Abort mid-data with reset, then send a clean frame.
    write_byte(8'hF0);
    repeat (3 * T) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    write_byte(8'h3C);
    drain("t5");

    // Write into a full FIFO on the exact cycle the stop bit pops the next byte.
    do_reset();
    write_byte(8'hA0);
    step();
    for (int i = 0; i < 4; i++) write_byte(8'hB0 + 8'(i));
    begin
      int n = 0;
      while (!(in_frame && cnt == 10 * T - 1) && n < 1000) begin
        step();
        n++;
      end
      check("t6_wait", {31'd0, (n < 1000)}, 32'd1);
    end
    write_byte(8'hEE);
    check("t6_count", q.size(), D - 1);
    drain("t6");

    // Random traffic with random enable spacing.
    do_reset();
    rand_clken = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) write_byte(8'($urandom));
      else step();
    end
    drain("rand");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
